// File: rtl/memory_cycle.sv
// rtl/memory_cycle.sv - MEM stage of the 5-stage RISC-V pipeline with MEM/WB register
//
// Purpose:
//   Holds a word-addressed data memory (DEPTH x 32) serving SW stores and LW
//   loads, registers the MEM/WB bundle, and drives ResultW combinationally for
//   write-back and execute-stage forwarding.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   Defined   -> adds MisalignW; misaligned stores are dropped, misaligned loads read 0.
//   Undefined -> address bits [1:0] are ignored (accesses forced to word alignment).
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   RegWriteM, MemWriteM     register write enable, store enable
//   ResultSrcM               0: ALU result, 1: load data
//   RD_M, PCPlus4M           destination register, PC+4
//   WriteDataM, ALU_ResultM  store data, byte address / ALU result
//   StallM, FlushM           hold MEM/WB and suppress store, insert bubble
//   RegWriteW .. ReadDataW   registered MEM/WB bundle
//   MisalignW                registered misalignment flag (macro only)
//   ResultW                  ResultSrcW ? ReadDataW : ALU_ResultW

module memory_cycle #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  input  logic        StallM,
  input  logic        FlushM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
`ifdef MEM_ALIGN_CHECK_EN
  output logic        MisalignW,
`endif
  output logic [31:0] ResultW
);

  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic              misalign;
  logic              store_en;
  logic [31:0]       load_data;

  logic              reg_write_q,  reg_write_d;
  logic              result_src_q, result_src_d;
  logic [4:0]        rd_q,         rd_d;
  logic [31:0]       pc_plus4_q,   pc_plus4_d;
  logic [31:0]       alu_result_q, alu_result_d;
  logic [31:0]       read_data_q,  read_data_d;
  logic              misalign_q,   misalign_d;

  // Address decode, combinational read and store qualification.
  always_comb begin
    idx     = ALU_ResultM[ADDR_W+1:2];
    rd_word = mem_q[idx];
`ifdef MEM_ALIGN_CHECK_EN
    misalign = (ALU_ResultM[1:0] != 2'b00) && (MemWriteM || ResultSrcM);
`else
    misalign = 1'b0;
`endif
    // Flush does not cancel the store; only a stall (or misalignment) does.
    store_en  = MemWriteM && !StallM && !misalign;
    load_data = (misalign && ResultSrcM) ? 32'h0 : rd_word;
  end

  // MEM/WB next-state: flush beats stall, stall holds, otherwise load.
  always_comb begin
    reg_write_d  = reg_write_q;
    result_src_d = result_src_q;
    rd_d         = rd_q;
    pc_plus4_d   = pc_plus4_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    misalign_d   = misalign_q;
    if (FlushM) begin
      reg_write_d  = 1'b0;
      result_src_d = 1'b0;
      rd_d         = 5'd0;
      pc_plus4_d   = 32'h0;
      alu_result_d = 32'h0;
      read_data_d  = 32'h0;
      misalign_d   = 1'b0;
    end else if (!StallM) begin
      reg_write_d  = RegWriteM;
      result_src_d = ResultSrcM;
      rd_d         = RD_M;
      pc_plus4_d   = PCPlus4M;
      alu_result_d = ALU_ResultM;
      read_data_d  = load_data;
      misalign_d   = misalign;
    end
  end

  // Data memory; the read above sees the pre-edge contents, giving
  // read-before-write on a same-index load/store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else if (store_en) begin
      mem_q[idx] <= WriteDataM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= 5'd0;
      pc_plus4_q   <= 32'h0;
      alu_result_q <= 32'h0;
      read_data_q  <= 32'h0;
      misalign_q   <= 1'b0;
    end else begin
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      misalign_q   <= misalign_d;
    end
  end

  assign RegWriteW   = reg_write_q;
  assign ResultSrcW  = result_src_q;
  assign RD_W        = rd_q;
  assign PCPlus4W    = pc_plus4_q;
  assign ALU_ResultW = alu_result_q;
  assign ReadDataW   = read_data_q;
  assign ResultW     = result_src_q ? read_data_q : alu_result_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign MisalignW   = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// tb/tb_memory_cycle.sv - self-checking bench for memory_cycle with a behavioural model

module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM, StallM, FlushM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW, ResultW;
`ifdef MEM_ALIGN_CHECK_EN
  logic        MisalignW;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state.
  logic [31:0] m_mem [64];
  logic        e_rw, e_rs, e_mis;
  logic [4:0]  e_rd;
  logic [31:0] e_pc, e_alu, e_rdata;

  always #5 clk = ~clk;

  memory_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM), .StallM(StallM), .FlushM(FlushM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW),
`ifdef MEM_ALIGN_CHECK_EN
    .MisalignW(MisalignW),
`endif
    .ResultW(ResultW)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
    e_rw = 0; e_rs = 0; e_mis = 0; e_rd = 0; e_pc = 0; e_alu = 0; e_rdata = 0;
  endtask

  // What one rising edge must do, from the stage's rules.
  task automatic model_edge();
    int          w;
    logic [31:0] old;
    logic        mis;
    if (!rst) begin
      model_clear();
    end else begin
      w   = int'(ALU_ResultM % 256) / 4;
      old = m_mem[w];
      mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis = (ALU_ResultM % 4 != 0) && (MemWriteM || ResultSrcM);
`endif
      if (FlushM) begin
        e_rw = 0; e_rs = 0; e_mis = 0; e_rd = 0; e_pc = 0; e_alu = 0; e_rdata = 0;
      end else if (!StallM) begin
        e_rw = RegWriteM; e_rs = ResultSrcM; e_rd = RD_M; e_pc = PCPlus4M;
        e_alu = ALU_ResultM; e_mis = mis;
        e_rdata = (mis && ResultSrcM) ? 32'h0 : old;
      end
      if (MemWriteM && !StallM && !mis) m_mem[w] = WriteDataM;
    end
  endtask

  // Compare process: outputs against the model every cycle once running.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("RegWriteW",   {31'h0, RegWriteW},  {31'h0, e_rw});
      chk("ResultSrcW",  {31'h0, ResultSrcW}, {31'h0, e_rs});
      chk("RD_W",        {27'h0, RD_W},       {27'h0, e_rd});
      chk("PCPlus4W",    PCPlus4W,            e_pc);
      chk("ALU_ResultW", ALU_ResultW,         e_alu);
      chk("ReadDataW",   ReadDataW,           e_rdata);
      chk("ResultW",     ResultW,             e_rs ? e_rdata : e_alu);
`ifdef MEM_ALIGN_CHECK_EN
      chk("MisalignW",   {31'h0, MisalignW},  {31'h0, e_mis});
`endif
    end
  end

  task automatic set(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                     input logic [31:0] wd, input logic [31:0] alu,
                     input logic stall, input logic flush);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd;
    PCPlus4M = alu + 32'h1000; WriteDataM = wd; ALU_ResultM = alu;
    StallM = stall; FlushM = flush;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) step();
    chk("reset_RegWriteW", {31'h0, RegWriteW}, 32'h0);
    chk("reset_ResultW", ResultW, 32'h0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // T2 store then load.
    set(0, 1, 0, 0, 32'hDEADBEEF, 32'h10, 0, 0); step();
    set(1, 0, 1, 5, 0, 32'h10, 0, 0);            step();
    chk("t2_ReadDataW", ReadDataW, 32'hDEADBEEF);
    chk("t2_ResultW", ResultW, 32'hDEADBEEF);
    chk("t2_RD_W", {27'h0, RD_W}, 32'd5);

    // T3 ALU pass-through.
    set(1, 0, 0, 2, 0, 32'h4, 0, 0); step();
    chk("t3_ResultW", ResultW, 32'h4);
    chk("t3_RegWriteW", {31'h0, RegWriteW}, 32'h1);

    // T4 wrap and read-before-write.
    set(0, 1, 1, 0, 32'h11, 32'h100, 0, 0); step();
    chk("t4_old_read", ReadDataW, 32'h0);
    set(1, 0, 1, 1, 0, 32'h0, 0, 0); step();
    chk("t4_wrapped_load", ReadDataW, 32'h11);

    // T5 stall / flush.
    set(1, 0, 0, 9, 0, 32'h40, 0, 0); step();
    set(1, 1, 0, 3, 32'h77, 32'h20, 1, 0); step();
    chk("t5_stall_RD_W", {27'h0, RD_W}, 32'd9);
    chk("t5_stall_ALU", ALU_ResultW, 32'h40);
    set(1, 0, 1, 4, 0, 32'h20, 0, 0); step();
    chk("t5_stall_nostore", ReadDataW, 32'h0);
    set(1, 1, 0, 7, 32'h99, 32'h28, 0, 1); step();
    chk("t5_flush_RegWriteW", {31'h0, RegWriteW}, 32'h0);
    chk("t5_flush_RD_W", {27'h0, RD_W}, 32'h0);
    set(1, 0, 1, 4, 0, 32'h28, 0, 0); step();
    chk("t5_flush_store_commits", ReadDataW, 32'h99);
    set(1, 1, 0, 7, 32'h55, 32'h24, 1, 1); step();
    chk("t5_both_RegWriteW", {31'h0, RegWriteW}, 32'h0);
    set(1, 0, 1, 4, 0, 32'h24, 0, 0); step();
    chk("t5_both_nostore", ReadDataW, 32'h0);

    // T6 misaligned store.
    set(0, 1, 0, 0, 32'h5, 32'h12, 0, 0); step();
`ifdef MEM_ALIGN_CHECK_EN
    chk("t6_MisalignW", {31'h0, MisalignW}, 32'h1);
`endif
    set(1, 0, 1, 6, 0, 32'h10, 0, 0); step();
`ifdef MEM_ALIGN_CHECK_EN
    chk("t6_word4", ReadDataW, 32'hDEADBEEF);
`else
    chk("t6_word4", ReadDataW, 32'h5);
`endif

    // T1 asynchronous reset mid-run; the store on the reset edge is lost.
    set(1, 1, 1, 8, 32'hABCD, 32'h10, 0, 0);
    rst = 1'b0;
    #1;
    chk("t1_RegWriteW", {31'h0, RegWriteW}, 32'h0);
    chk("t1_RD_W", {27'h0, RD_W}, 32'h0);
    chk("t1_ReadDataW", ReadDataW, 32'h0);
    chk("t1_ResultW", ResultW, 32'h0);
    model_clear();
    repeat (2) step();
    rst = 1'b1;
    set(1, 0, 1, 8, 0, 32'h10, 0, 0); step();
    chk("t1_mem_cleared", ReadDataW, 32'h0);

    // Randomized traffic over a small address window with random upper bits.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 15), 28'h0} | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      set(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)),
          5'($urandom), $urandom, a,
          1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 9) < 1));
      step();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
